ifu_line_fill: RTL and testbench
================================

# ifu_line_fill

Line-fill engine between the `ifu_cache` miss port and the word-wide instruction memory. It latches a missed tag and issues the line's word reads in order with a valid/ready handshake. It assembles the in-order read data into one line and returns it to the cache as a single-cycle tagged response pulse.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 256: watchdog limit. Only used with `IFU_LINE_FILL_TIMEOUT_EN`.

Ports (clock and reset first):
- `Clock` in 1: single clock, rising edge.
- `Rst` in 1: reset, asynchronous, active-low.
- `cache_reqTagIn` in TAG_WIDTH: missed tag from the cache.
- `cache_reqTagValidIn` in 1: miss request. Level signal, held while the cache misses.
- `cache_rspTagOut` out TAG_WIDTH: tag of the delivered line.
- `cache_rspInsLineOut` out LINE_WIDTH: assembled line.
- `cache_rspInsLineValidOut` out 1: one-cycle delivery pulse.
- `imem_reqAddrOut` out ADDR_WIDTH: word read address.
- `imem_reqValidOut` out 1: read request valid.
- `imem_reqReadyIn` in 1: memory accepts the request.
- `imem_rspDataIn` in WORD_WIDTH: read data.
- `imem_rspValidIn` in 1: read data valid. Responses return in request order.
- `busyOut` out 1: high in every state except IDLE.
- `errorOut` out 1: one-cycle pulse on timeout. Tied to 0 when the watchdog is compiled out.

## Operation
- FSM states: IDLE, REQ, WAIT, DELIVER.
- IDLE:
  - On `cache_reqTagValidIn`=1, latch `cache_reqTagIn` into fillTag.
  - Clear txCnt, rxCnt and the line buffer, then go to REQ.
- REQ:
  - `imem_reqValidOut`=1 with `imem_reqAddrOut` = {fillTag, txCnt[WORD_IDX_WIDTH-1:0], 2'b00}.
  - txCnt increments on each valid&&ready handshake.
  - After the handshake with txCnt = WORDS_PER_LINE-1, drop valid and go to WAIT. Go directly to DELIVER if rxCnt also completes that cycle.
- Response capture, active in REQ and WAIT:
  - On `imem_rspValidIn`, write data into linebuf[rxCnt*WORD_WIDTH +: WORD_WIDTH] and increment rxCnt.
  - When the final word is captured, go to DELIVER.
- DELIVER:
  - `cache_rspInsLineValidOut`=1 for exactly one cycle; next state is IDLE.
  - `cache_rspTagOut` and `cache_rspInsLineOut` are registered. They stay stable from DELIVER until the next IDLE->REQ transition.
- `cache_reqTagValidIn` is ignored outside IDLE:
  - If it drops or its tag changes mid-fill (redirect), the fill still completes and delivers the original tag.
  - The cache discards a mismatching tag.
- `imem_rspValidIn` in IDLE or DELIVER is a stray response: ignored, no state change.
- Counter widths:
  - txCnt and rxCnt are WORD_IDX_WIDTH+1 bits.
  - The address uses the low WORD_IDX_WIDTH bits only, so there is no wrap.
  - Response capture never exceeds WORDS_PER_LINE.
- Reset (Rst=0, at any time including mid-fill) forces:
  - state IDLE;
  - txCnt, rxCnt, fillTag and linebuf cleared;
  - all outputs 0.
- An in-flight memory response arriving after reset release lands in IDLE and is ignored.

## Timing
- Zero-wait memory (ready=1, response one cycle after handshake), with request first seen in IDLE at cycle 0:
  - REQ handshakes in cycles 1-4;
  - responses in cycles 2-5;
  - DELIVER pulse in cycle 6.
- IDLE is entered in cycle 7. Since the cache now hits, a new fill is not started for the same line.
- No combinational path from any input to any output; all outputs are registered.
- Back-to-back fills: minimum two idle-to-idle cycles between DELIVER pulses (DELIVER, then IDLE).

## Configuration
- `IFU_LINE_FILL_TIMEOUT_EN` defined:
  - A watchdog counts cycles in REQ/WAIT and clears on any request handshake or accepted response.
  - Reaching TIMEOUT_CYCLES-1 aborts the fill: `errorOut` pulses for one cycle, state goes to IDLE, and there is no DELIVER.
  - Later stray responses are ignored per the IDLE rule.
- Undefined: no watchdog, `errorOut`=0, and a fill waits indefinitely.

## Structure
- `ifu_pkg` gains:
  - WORD_WIDTH=32;
  - WORDS_PER_LINE = LINE_WIDTH/WORD_WIDTH;
  - WORD_IDX_WIDTH = $clog2(WORDS_PER_LINE);
  - enum fill_state_t {FILL_IDLE, FILL_REQ, FILL_WAIT, FILL_DELIVER}.
- Existing ADDR_WIDTH/TAG_WIDTH/LINE_WIDTH/OFFSET_WIDTH are reused.
- Sub-module `ifu_fill_watchdog` (counter, clear, expire pulse) is instantiated only under `IFU_LINE_FILL_TIMEOUT_EN`.

## Test plan
- Zero-wait fill of tag 0x0000123, memory returning word i = 0xA0+i:
  - addresses 0x1230, 0x1234, 0x1238, 0x123C;
  - DELIVER at cycle 6 with line 0x000000A3_000000A2_000000A1_000000A0.
- Fill with `imem_reqReadyIn` low for 3 cycles before word 2: `imem_reqAddrOut` holds 0x…8 stable while stalled, and the delivered line is identical.
- `cache_reqTagValidIn` drops after cycle 1: fill completes, one pulse with the original tag, then `busyOut`=0.
- Rst asserted after 2 responses: all outputs 0 immediately; a late response is ignored; the next fill delivers correct data.
- With `IFU_LINE_FILL_TIMEOUT_EN` and TIMEOUT_CYCLES=16: no responses -> `errorOut` pulse, IDLE, no `cache_rspInsLineValidOut`.

Source files
------------

// File: rtl/ifu_pkg.sv
// Shared widths and fill-engine state encoding for the instruction fetch unit.
// The line-fill address is formed as {tag, word index, byte offset within word}.
package ifu_pkg;

    localparam int ADDR_WIDTH     = 32;
    localparam int LINE_WIDTH     = 128;
    localparam int OFFSET_WIDTH   = $clog2(LINE_WIDTH / 8);
    localparam int TAG_WIDTH      = ADDR_WIDTH - OFFSET_WIDTH;
    localparam int WORD_WIDTH     = 32;
    localparam int WORDS_PER_LINE = LINE_WIDTH / WORD_WIDTH;
    localparam int WORD_IDX_WIDTH = $clog2(WORDS_PER_LINE);
    localparam int CNT_WIDTH      = WORD_IDX_WIDTH + 1;

    typedef enum logic [1:0] {
        FILL_IDLE,
        FILL_REQ,
        FILL_WAIT,
        FILL_DELIVER
    } fill_state_t;

    function automatic logic [ADDR_WIDTH-1:0] word_addr(
        input logic [TAG_WIDTH-1:0] tag,
        input logic [CNT_WIDTH-1:0] idx
    );
        return {tag, idx[WORD_IDX_WIDTH-1:0], 2'b00};
    endfunction

endpackage

// File: rtl/ifu_fill_watchdog.sv
// Idle-progress watchdog for the line-fill engine: counts active cycles without
// progress and raises a single-cycle expire when the limit is reached.
module ifu_fill_watchdog #(
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic clk,
    input  logic rst_n,
    input  logic active,
    input  logic clear,
    output logic expire
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (!active || clear) begin
            count <= '0;
        end else begin
            count <= count + CW'(1);
        end
    end

    assign expire = active && !clear && (count == CW'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/ifu_line_fill.sv
// Line-fill engine: fetches one cache line word by word from instruction memory
// and returns it as a tagged single-cycle pulse. Watchdog: IFU_LINE_FILL_TIMEOUT_EN.
module ifu_line_fill
    import ifu_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic                  Clock,
    input  logic                  Rst,
    input  logic [TAG_WIDTH-1:0]  cache_reqTagIn,
    input  logic                  cache_reqTagValidIn,
    output logic [TAG_WIDTH-1:0]  cache_rspTagOut,
    output logic [LINE_WIDTH-1:0] cache_rspInsLineOut,
    output logic                  cache_rspInsLineValidOut,
    output logic [ADDR_WIDTH-1:0] imem_reqAddrOut,
    output logic                  imem_reqValidOut,
    input  logic                  imem_reqReadyIn,
    input  logic [WORD_WIDTH-1:0] imem_rspDataIn,
    input  logic                  imem_rspValidIn,
    output logic                  busyOut,
    output logic                  errorOut
);

    fill_state_t           state;
    logic [TAG_WIDTH-1:0]  fill_tag;
    logic [CNT_WIDTH-1:0]  tx_cnt;
    logic [CNT_WIDTH-1:0]  rx_cnt;
    logic [LINE_WIDTH-1:0] line_buf;
    logic [LINE_WIDTH-1:0] line_merged;

    logic filling;
    logic req_fire;
    logic rsp_take;
    logic tx_last;
    logic rx_last;
    logic timeout_hit;

    assign filling  = (state == FILL_REQ) || (state == FILL_WAIT);
    assign req_fire = (state == FILL_REQ) && imem_reqValidOut && imem_reqReadyIn;
    assign rsp_take = filling && imem_rspValidIn && (rx_cnt < CNT_WIDTH'(WORDS_PER_LINE));
    assign tx_last  = req_fire && (tx_cnt == CNT_WIDTH'(WORDS_PER_LINE - 1));
    assign rx_last  = rsp_take && (rx_cnt == CNT_WIDTH'(WORDS_PER_LINE - 1));

    // Line as it will look once this cycle's response word is written in.
    always_comb begin
        line_merged = line_buf;
        line_merged[rx_cnt[WORD_IDX_WIDTH-1:0]*WORD_WIDTH +: WORD_WIDTH] = imem_rspDataIn;
    end

`ifdef IFU_LINE_FILL_TIMEOUT_EN
    ifu_fill_watchdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk    (Clock),
        .rst_n  (Rst),
        .active (filling),
        .clear  (req_fire || rsp_take),
        .expire (timeout_hit)
    );
`else
    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge Clock or negedge Rst) begin
        if (!Rst) begin
            state                    <= FILL_IDLE;
            fill_tag                 <= '0;
            tx_cnt                   <= '0;
            rx_cnt                   <= '0;
            line_buf                 <= '0;
            cache_rspTagOut          <= '0;
            cache_rspInsLineOut      <= '0;
            cache_rspInsLineValidOut <= 1'b0;
            imem_reqAddrOut          <= '0;
            imem_reqValidOut         <= 1'b0;
            busyOut                  <= 1'b0;
            errorOut                 <= 1'b0;
        end else begin
            cache_rspInsLineValidOut <= 1'b0;
            errorOut                 <= 1'b0;
            case (state)
                FILL_IDLE: begin
                    busyOut <= 1'b0;
                    if (cache_reqTagValidIn) begin
                        fill_tag         <= cache_reqTagIn;
                        tx_cnt           <= '0;
                        rx_cnt           <= '0;
                        line_buf         <= '0;
                        imem_reqAddrOut  <= word_addr(cache_reqTagIn, '0);
                        imem_reqValidOut <= 1'b1;
                        busyOut          <= 1'b1;
                        state            <= FILL_REQ;
                    end
                end
                FILL_REQ, FILL_WAIT: begin
                    if (req_fire) begin
                        tx_cnt          <= tx_cnt + CNT_WIDTH'(1);
                        imem_reqAddrOut <= word_addr(fill_tag, tx_cnt + CNT_WIDTH'(1));
                        if (tx_last) begin
                            imem_reqValidOut <= 1'b0;
                        end
                    end
                    if (rsp_take) begin
                        line_buf <= line_merged;
                        rx_cnt   <= rx_cnt + CNT_WIDTH'(1);
                    end
                    // Abort wins over completion; the two cannot coincide since
                    // an accepted response clears the watchdog.
                    if (timeout_hit) begin
                        imem_reqValidOut <= 1'b0;
                        busyOut          <= 1'b0;
                        errorOut         <= 1'b1;
                        state            <= FILL_IDLE;
                    end else if (rx_last) begin
                        imem_reqValidOut         <= 1'b0;
                        cache_rspTagOut          <= fill_tag;
                        cache_rspInsLineOut      <= line_merged;
                        cache_rspInsLineValidOut <= 1'b1;
                        state                    <= FILL_DELIVER;
                    end else if (tx_last) begin
                        state <= FILL_WAIT;
                    end
                end
                FILL_DELIVER: begin
                    busyOut <= 1'b0;
                    state   <= FILL_IDLE;
                end
                default: begin
                    busyOut <= 1'b0;
                    state   <= FILL_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ifu_line_fill.sv
// Directed bench for ifu_line_fill: in-order memory responder plus a delivery
// scoreboard; the watchdog scenario runs only when IFU_LINE_FILL_TIMEOUT_EN is set.
module tb_ifu_line_fill;
    import ifu_pkg::*;

    logic                  Clock;
    logic                  Rst;
    logic [TAG_WIDTH-1:0]  tag_in;
    logic                  tag_valid;
    logic [TAG_WIDTH-1:0]  rsp_tag;
    logic [LINE_WIDTH-1:0] rsp_line;
    logic                  rsp_valid;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic                  req_valid;
    logic                  req_ready;
    logic [WORD_WIDTH-1:0] rsp_data;
    logic                  rsp_data_valid;
    logic                  busy;
    logic                  error;

    typedef struct {
        logic [TAG_WIDTH-1:0]  tag;
        logic [LINE_WIDTH-1:0] line;
    } exp_t;

    exp_t                  sb[$];
    int                    checks = 0;
    int                    errors = 0;
    int                    pulses = 0;
    int                    pushes = 0;
    logic                  mem_mute = 1'b0;
    logic [WORD_WIDTH-1:0] data_base = '0;

    ifu_line_fill #(
        .TIMEOUT_CYCLES (16)
    ) dut (
        .Clock                    (Clock),
        .Rst                      (Rst),
        .cache_reqTagIn           (tag_in),
        .cache_reqTagValidIn      (tag_valid),
        .cache_rspTagOut          (rsp_tag),
        .cache_rspInsLineOut      (rsp_line),
        .cache_rspInsLineValidOut (rsp_valid),
        .imem_reqAddrOut          (req_addr),
        .imem_reqValidOut         (req_valid),
        .imem_reqReadyIn          (req_ready),
        .imem_rspDataIn           (rsp_data),
        .imem_rspValidIn          (rsp_data_valid),
        .busyOut                  (busy),
        .errorOut                 (error)
    );

    initial begin
        Clock = 1'b0;
        forever #5 Clock = ~Clock;
    end

    function automatic logic [LINE_WIDTH-1:0] make_line(input logic [WORD_WIDTH-1:0] base);
        logic [LINE_WIDTH-1:0] l;
        l = '0;
        for (int i = 0; i < WORDS_PER_LINE; i++) begin
            l[i*WORD_WIDTH +: WORD_WIDTH] = base + WORD_WIDTH'(i);
        end
        return l;
    endfunction

    task automatic check_output(input string name, input logic [LINE_WIDTH-1:0] observed,
                                input logic [LINE_WIDTH-1:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", name, observed, expected);
        end
    endtask

    // Cycle-0 drive of a miss; a fill that should deliver is recorded in the scoreboard.
    task automatic apply_stimulus(input logic [TAG_WIDTH-1:0] tag, input logic [WORD_WIDTH-1:0] base,
                                  input bit expect_delivery);
        tag_in    = tag;
        tag_valid = 1'b1;
        data_base = base;
        if (expect_delivery) begin
            sb.push_back('{tag: tag, line: make_line(base)});
            pushes++;
        end
    endtask

    // Zero-latency-after-handshake memory: word i of a line reads as base + i.
    initial begin
        logic                  fire;
        logic [ADDR_WIDTH-1:0] fire_addr;
        rsp_data_valid = 1'b0;
        rsp_data       = '0;
        forever begin
            @(posedge Clock);
            fire      = req_valid && req_ready && !mem_mute;
            fire_addr = req_addr;
            #1;
            rsp_data_valid = fire;
            rsp_data       = fire ? data_base + WORD_WIDTH'(fire_addr[3:2]) : '0;
        end
    end

    // Delivery monitor: every pulse must match the oldest outstanding fill.
    initial begin
        exp_t e;
        forever begin
            @(negedge Clock);
            if (rsp_valid === 1'b1) begin
                pulses++;
                checks++;
                assert (sb.size() != 0) else begin
                    errors++;
                    $error("[TB] FAIL unexpected_delivery observed_tag=%h expected=none", rsp_tag);
                end
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    check_output("sb_tag", LINE_WIDTH'(rsp_tag), LINE_WIDTH'(e.tag));
                    check_output("sb_line", rsp_line, e.line);
                end
            end
        end
    end

    initial begin
        int err_cycle;
        Rst       = 1'b0;
        tag_in    = '0;
        tag_valid = 1'b0;
        req_ready = 1'b1;

        repeat (3) @(negedge Clock);
        check_output("reset_rsp_valid", LINE_WIDTH'(rsp_valid), '0);
        check_output("reset_req_valid", LINE_WIDTH'(req_valid), '0);
        check_output("reset_addr", LINE_WIDTH'(req_addr), '0);
        check_output("reset_busy", LINE_WIDTH'(busy), '0);
        check_output("reset_line", rsp_line, '0);
        check_output("reset_error", LINE_WIDTH'(error), '0);
        Rst = 1'b1;
        @(negedge Clock);

        // Zero-wait fill of tag 0x123.
        apply_stimulus(28'h0000123, 32'h000000A0, 1'b1);
        @(negedge Clock);
        tag_valid = 1'b0;
        check_output("zw_valid_c1", LINE_WIDTH'(req_valid), 1);
        check_output("zw_busy_c1", LINE_WIDTH'(busy), 1);
        check_output("zw_addr_c1", LINE_WIDTH'(req_addr), 128'h1230);
        @(negedge Clock);
        check_output("zw_addr_c2", LINE_WIDTH'(req_addr), 128'h1234);
        @(negedge Clock);
        check_output("zw_addr_c3", LINE_WIDTH'(req_addr), 128'h1238);
        @(negedge Clock);
        check_output("zw_addr_c4", LINE_WIDTH'(req_addr), 128'h123C);
        @(negedge Clock);
        check_output("zw_valid_c5", LINE_WIDTH'(req_valid), 0);
        check_output("zw_pulse_c5", LINE_WIDTH'(rsp_valid), 0);
        @(negedge Clock);
        check_output("zw_pulse_c6", LINE_WIDTH'(rsp_valid), 1);
        check_output("zw_line_c6", rsp_line, 128'h000000A3_000000A2_000000A1_000000A0);
        @(negedge Clock);
        check_output("zw_pulse_c7", LINE_WIDTH'(rsp_valid), 0);
        check_output("zw_busy_c7", LINE_WIDTH'(busy), 0);
        check_output("zw_error_c7", LINE_WIDTH'(error), 0);
        check_output("zw_line_hold", rsp_line, 128'h000000A3_000000A2_000000A1_000000A0);
        repeat (2) @(negedge Clock);

        // Memory stalls for three cycles before word 2.
        apply_stimulus(28'h0000123, 32'h000000A0, 1'b1);
        @(negedge Clock);
        tag_valid = 1'b0;
        @(negedge Clock);
        check_output("st_addr_c2", LINE_WIDTH'(req_addr), 128'h1234);
        for (int c = 3; c <= 5; c++) begin
            @(negedge Clock);
            req_ready = 1'b0;
            check_output("st_addr_hold", LINE_WIDTH'(req_addr), 128'h1238);
            check_output("st_valid_hold", LINE_WIDTH'(req_valid), 1);
        end
        @(negedge Clock);
        req_ready = 1'b1;
        check_output("st_addr_c6", LINE_WIDTH'(req_addr), 128'h1238);
        @(negedge Clock);
        check_output("st_addr_c7", LINE_WIDTH'(req_addr), 128'h123C);
        @(negedge Clock);
        check_output("st_valid_c8", LINE_WIDTH'(req_valid), 0);
        @(negedge Clock);
        check_output("st_pulse_c9", LINE_WIDTH'(rsp_valid), 1);
        check_output("st_line_c9", rsp_line, 128'h000000A3_000000A2_000000A1_000000A0);
        @(negedge Clock);
        check_output("st_busy_c10", LINE_WIDTH'(busy), 0);
        repeat (2) @(negedge Clock);

        // Redirect mid-fill: tag changes, then the request drops.
        apply_stimulus(28'h0000ABC, 32'h10000000, 1'b1);
        @(negedge Clock);
        tag_in = 28'h0000DEF;
        @(negedge Clock);
        tag_valid = 1'b0;
        @(negedge Clock);
        check_output("rd_addr_c3", LINE_WIDTH'(req_addr), 128'hABC8);
        repeat (3) @(negedge Clock);
        check_output("rd_pulse_c6", LINE_WIDTH'(rsp_valid), 1);
        check_output("rd_tag_c6", LINE_WIDTH'(rsp_tag), 128'hABC);
        @(negedge Clock);
        check_output("rd_busy_c7", LINE_WIDTH'(busy), 0);
        repeat (3) @(negedge Clock);
        check_output("rd_busy_idle", LINE_WIDTH'(busy), 0);

        // Reset after two responses; the third response lands in IDLE.
        apply_stimulus(28'h0000777, 32'h20000000, 1'b0);
        @(negedge Clock);
        tag_valid = 1'b0;
        repeat (3) @(negedge Clock);
        Rst = 1'b0;
        #1;
        check_output("rs_req_valid", LINE_WIDTH'(req_valid), 0);
        check_output("rs_busy", LINE_WIDTH'(busy), 0);
        check_output("rs_addr", LINE_WIDTH'(req_addr), 0);
        check_output("rs_line", rsp_line, 0);
        check_output("rs_tag", LINE_WIDTH'(rsp_tag), 0);
        #1;
        Rst = 1'b1;
        check_output("rs_late_rsp_present", LINE_WIDTH'(rsp_data_valid), 1);
        @(negedge Clock);
        check_output("rs_after_busy", LINE_WIDTH'(busy), 0);
        check_output("rs_after_valid", LINE_WIDTH'(req_valid), 0);
        @(negedge Clock);
        check_output("rs_after_busy2", LINE_WIDTH'(busy), 0);

        apply_stimulus(28'h0000321, 32'h30000000, 1'b1);
        @(negedge Clock);
        tag_valid = 1'b0;
        check_output("rf_addr_c1", LINE_WIDTH'(req_addr), 128'h3210);
        repeat (5) @(negedge Clock);
        check_output("rf_pulse_c6", LINE_WIDTH'(rsp_valid), 1);
        check_output("rf_line_c6", rsp_line, make_line(32'h30000000));
        @(negedge Clock);
        check_output("rf_busy_c7", LINE_WIDTH'(busy), 0);
        repeat (2) @(negedge Clock);

`ifdef IFU_LINE_FILL_TIMEOUT_EN
        // Silent memory: watchdog aborts 16 cycles after the last handshake.
        mem_mute = 1'b1;
        apply_stimulus(28'h0000999, 32'h40000000, 1'b0);
        err_cycle = -1;
        for (int c = 1; c <= 40; c++) begin
            @(negedge Clock);
            if (c == 1) tag_valid = 1'b0;
            if (error === 1'b1 && err_cycle < 0) err_cycle = c;
        end
        check_output("to_error_cycle", LINE_WIDTH'(err_cycle), 128'd21);
        check_output("to_busy_after", LINE_WIDTH'(busy), 0);
        check_output("to_error_after", LINE_WIDTH'(error), 0);
        mem_mute = 1'b0;
`else
        err_cycle = 0;
        check_output("no_wd_error", LINE_WIDTH'(error), LINE_WIDTH'(err_cycle));
`endif

        repeat (3) @(negedge Clock);
        check_output("total_pulses", LINE_WIDTH'(pulses), LINE_WIDTH'(pushes));
        check_output("sb_empty", LINE_WIDTH'(sb.size()), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
